mul_share_arbiter: RTL and testbench
====================================

MUL_SHARE_ARBITER -- requirements
Module: mul_share_arbiter

Interface
REQ-001 Parameter: OP_W, default 4, operand width; the product width is 2*OP_W.
REQ-002 clk  in  1  the single clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 req0_valid  in  1  requester 0 has an operand pair pending.
REQ-005 req0_a, req0_b  in  OP_W each  requester 0 operands.
REQ-006 req0_ready  out  1  requester 0 operands accepted this cycle.
REQ-007 req1_valid, req1_a, req1_b, req1_ready  same as REQ-004..006 for requester 1.
REQ-008 resp0_valid  out  1  product for requester 0 available.
REQ-009 resp0_product  out  2*OP_W  product for requester 0.
REQ-010 resp0_ready  in  1  requester 0 takes the product this cycle.
REQ-011 resp1_valid, resp1_product, resp1_ready  same as REQ-008..010 for requester 1.
REQ-012 mul_a, mul_b  out  OP_W each  operands driven to the shared external combinational unsigned multiplier.
REQ-013 mul_product  in  2*OP_W  result returned from the shared multiplier.
REQ-014 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-015 FSM states: IDLE, MUL, RESP; encoding is free.
REQ-016 IDLE:
- req_ready is asserted to the arbitration winner only, combinationally from the req_valid inputs and the rr pointer.
- A handshake (valid & ready) captures that requester's a/b into the op_a/op_b registers, records the winner in gnt_id, and moves to MUL.
REQ-017 Arbitration is round-robin with a 1-bit pointer rr that names the preferred requester.
- Both valid: the requester named by rr wins.
- Exactly one valid: that requester wins regardless of rr.
- On each accepted request, rr is set to the requester that lost.
REQ-018 mul_a/mul_b shall equal op_a/op_b at all times, including in IDLE.
REQ-019 MUL lasts exactly one cycle: mul_product is captured into prod_reg, then the FSM moves to RESP.
REQ-020 RESP asserts resp<gnt_id>_valid with resp<gnt_id>_product = prod_reg; the other resp_valid stays low.
REQ-021 RESP holds, with the product stable, until resp<gnt_id>_ready is high, then returns to IDLE.
- resp_ready of the non-granted requester is ignored.
REQ-022 Latency:
- Request accepted at edge N → resp_valid high from edge N+2.
- If resp_ready is held high, the next request can be accepted at edge N+4 at the earliest.
REQ-023 Both req_ready outputs are low in MUL and RESP; a new request is never accepted while one is in flight.
REQ-024 resp_productX shall be 0 whenever respX_valid is low.
REQ-025 Arithmetic is unsigned.
- The product passes through unmodified at full 2*OP_W width; no truncation or saturation.
- 15*15 = 225 (8'b11100001) for OP_W=4.
REQ-026 The block does not check the requester's req_valid after acceptance; a requester dropping req_valid mid-operation does not abort it.
REQ-027 No combinational path from resp_ready to req_ready.

Reset
REQ-028 While rst is high, independent of clk:
- state = IDLE, rr = 0, gnt_id = 0.
- op_a, op_b = 0; prod_reg = 0.
- All req_ready, resp_valid and busy low; all products 0.
REQ-029 Assertion of rst in MUL or RESP discards the in-flight operation; no resp_valid is produced for it after rst deasserts.
REQ-030 First accept is possible at the first rising edge after rst deasserts.

Verification
REQ-031 Single request: req0 a=4'b0011, b=4'b0101, resp0_ready=1 → resp0_valid two edges after accept, resp0_product=8'b00001111 (15), busy high for 3 cycles.
REQ-032 Contention: both valid continuously after reset (req0 3*4, req1 15*15), resp_ready=1 → grant order 0,1,0,1; products 12 and 225 routed to the correct resp port each time.
REQ-033 Backpressure: resp1_ready=0 for 5 cycles after resp1_valid rises →
- resp1_valid and product remain stable;
- req0_ready and req1_ready remain low;
- completion occurs the cycle resp1_ready rises.
REQ-034 Exhaustive: all 256 operand pairs sequentially via requester 1 → each resp1_product equals a*b.
REQ-035 Reset mid-operation: assert rst during MUL → all outputs 0 immediately (asynchronously); after release, no stale resp_valid, rr=0.
REQ-036 Wrong-port ready: in RESP with gnt_id=0, pulse resp1_ready only → no state change; resp0_valid stays high.

Source files
------------

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter
// Shares one external combinational unsigned multiplier between two
// requesters. A round-robin arbiter picks one operand pair at a time. The
// pair is held in op_a/op_b while the product is computed. The product is
// then returned on the winner's response port until that requester takes it.
// Only one operation is ever in flight.

module mul_share_arbiter #(
    parameter int OP_W = 4
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                req0_valid,
    input  logic [OP_W-1:0]     req0_a,
    input  logic [OP_W-1:0]     req0_b,
    output logic                req0_ready,

    input  logic                req1_valid,
    input  logic [OP_W-1:0]     req1_a,
    input  logic [OP_W-1:0]     req1_b,
    output logic                req1_ready,

    output logic                resp0_valid,
    output logic [2*OP_W-1:0]   resp0_product,
    input  logic                resp0_ready,

    output logic                resp1_valid,
    output logic [2*OP_W-1:0]   resp1_product,
    input  logic                resp1_ready,

    output logic [OP_W-1:0]     mul_a,
    output logic [OP_W-1:0]     mul_b,
    input  logic [2*OP_W-1:0]   mul_product,

    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        RESP
    } state_t;

    state_t              state;
    logic                rr;
    logic                gnt_id;
    logic [OP_W-1:0]     op_a;
    logic [OP_W-1:0]     op_b;
    logic [2*OP_W-1:0]   prod_reg;

    logic                win1;
    logic                any_valid;
    logic                offer;
    logic                resp_done;

    // Pick the arbitration winner: rr breaks ties, a lone requester always wins.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        win1      = req1_valid & (~req0_valid | rr);
        offer     = (state == IDLE) & any_valid & ~rst;
    end

    // Ready goes only to the winner and only in IDLE. It depends on nothing
    // on the response side.
    assign req0_ready = offer & ~win1;
    assign req1_ready = offer &  win1;

    // The multiplier always sees the held operands, even in IDLE.
    assign mul_a = op_a;
    assign mul_b = op_b;

    // A response completes only through the granted port's ready. The other
    // port's ready is ignored.
    assign resp_done = gnt_id ? (resp1_valid & resp1_ready)
                              : (resp0_valid & resp0_ready);

    // Control FSM with registered response and busy outputs. The first RESP
    // cycle loads the response registers from prod_reg. resp_valid rises one
    // edge after that and is held until the granted requester takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            rr            <= 1'b0;
            gnt_id        <= 1'b0;
            op_a          <= '0;
            op_b          <= '0;
            prod_reg      <= '0;
            resp0_valid   <= 1'b0;
            resp1_valid   <= 1'b0;
            resp0_product <= '0;
            resp1_product <= '0;
            busy          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        op_a   <= win1 ? req1_a : req0_a;
                        op_b   <= win1 ? req1_b : req0_b;
                        gnt_id <= win1;
                        rr     <= ~win1;
                        busy   <= 1'b1;
                        state  <= MUL;
                    end
                end
                MUL: begin
                    prod_reg <= mul_product;
                    state    <= RESP;
                end
                RESP: begin
                    if (resp_done) begin
                        resp0_valid   <= 1'b0;
                        resp1_valid   <= 1'b0;
                        resp0_product <= '0;
                        resp1_product <= '0;
                        busy          <= 1'b0;
                        state         <= IDLE;
                    end else if (!resp0_valid && !resp1_valid) begin
                        if (gnt_id) begin
                            resp1_valid   <= 1'b1;
                            resp1_product <= prod_reg;
                        end else begin
                            resp0_valid   <= 1'b1;
                            resp0_product <= prod_reg;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter
// Directed and randomized checks of mul_share_arbiter against a
// transaction-level model. The model covers round-robin winner choice,
// product = a*b, and fixed response timing. An ideal multiplier drives
// mul_product from mul_a/mul_b.

module tb_mul_share_arbiter;

    localparam int W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req1_valid;
    logic [W-1:0]     req0_a, req0_b, req1_a, req1_b;
    logic             req0_ready, req1_ready;
    logic             resp0_valid, resp1_valid;
    logic [2*W-1:0]   resp0_product, resp1_product;
    logic             resp0_ready, resp1_ready;
    logic [W-1:0]     mul_a, mul_b;
    logic [2*W-1:0]   mul_product;
    logic             busy;

    int tests = 0;
    int fails = 0;
    int rrModel = 0;

    mul_share_arbiter #(.OP_W(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .resp0_valid(resp0_valid), .resp0_product(resp0_product), .resp0_ready(resp0_ready),
        .resp1_valid(resp1_valid), .resp1_product(resp1_product), .resp1_ready(resp1_ready),
        .mul_a(mul_a), .mul_b(mul_b), .mul_product(mul_product),
        .busy(busy)
    );

    // Ideal external unsigned multiplier
    assign mul_product = (2*W)'(mul_a) * (2*W)'(mul_b);

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                                 input logic v1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                                 input logic r0, input logic r1);
        req0_valid  = v0;  req0_a = a0;  req0_b = b0;
        req1_valid  = v1;  req1_a = a1;  req1_b = b1;
        resp0_ready = r0;  resp1_ready = r1;
    endtask

    // Every output must be quiet, as in reset or idle with no requests pending.
    task automatic checkQuiet(input string tag);
        checkOutput({tag, "_busy"},   16'(busy),          16'(0));
        checkOutput({tag, "_rv0"},    16'(resp0_valid),   16'(0));
        checkOutput({tag, "_rv1"},    16'(resp1_valid),   16'(0));
        checkOutput({tag, "_rp0"},    16'(resp0_product), 16'(0));
        checkOutput({tag, "_rp1"},    16'(resp1_product), 16'(0));
    endtask

    // One complete transaction, called on a negedge while the DUT is idle.
    // The winner and product come from the arbitration rules and plain
    // multiplication. The timing is fixed: response valid two edges after
    // accept, completion on the edge that sees the granted ready.
    task automatic serveTxn(input logic v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                            input logic v1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                            input int stall, input bit hold);
        int             win;
        logic [W-1:0]   ea, eb;
        logic [2*W-1:0] expProd;
        win     = (v0 && v1) ? rrModel : (v1 ? 1 : 0);
        ea      = win ? a1 : a0;
        eb      = win ? b1 : b0;
        expProd = (2*W)'(ea) * (2*W)'(eb);

        applyStimulus(v0, a0, b0, v1, a1, b1, 1'b0, 1'b0);
        #1;
        checkOutput("req0_ready_idle", 16'(req0_ready), 16'(win == 0));
        checkOutput("req1_ready_idle", 16'(req1_ready), 16'(win == 1));
        tick();
        rrModel = 1 - win;

        // Dropping the request after accept must not disturb the operation.
        if (!hold) applyStimulus(1'b0, ~a0, ~b0, 1'b0, ~a1, ~b1, 1'b0, 1'b0);
        #1;
        checkOutput("busy_mul",   16'(busy),        16'(1));
        checkOutput("ready0_mul", 16'(req0_ready),  16'(0));
        checkOutput("ready1_mul", 16'(req1_ready),  16'(0));
        checkOutput("mul_a",      16'(mul_a),       16'(ea));
        checkOutput("mul_b",      16'(mul_b),       16'(eb));
        checkOutput("rv0_n1",     16'(resp0_valid), 16'(0));
        checkOutput("rv1_n1",     16'(resp1_valid), 16'(0));
        tick();
        checkOutput("busy_n2",    16'(busy),        16'(1));
        checkOutput("rv0_n2",     16'(resp0_valid), 16'(0));
        checkOutput("rv1_n2",     16'(resp1_valid), 16'(0));
        tick();
        for (int k = 0; k <= stall; k++) begin
            checkOutput("busy_resp",   16'(busy),          16'(1));
            checkOutput("rv0_resp",    16'(resp0_valid),   16'(win == 0));
            checkOutput("rv1_resp",    16'(resp1_valid),   16'(win == 1));
            checkOutput("rp0_resp",    16'(resp0_product), win == 0 ? 16'(expProd) : 16'(0));
            checkOutput("rp1_resp",    16'(resp1_product), win == 1 ? 16'(expProd) : 16'(0));
            checkOutput("ready0_resp", 16'(req0_ready),    16'(0));
            checkOutput("ready1_resp", 16'(req1_ready),    16'(0));
            if (k < stall) begin
                // Hold back the granted ready and toggle the other port's ready.
                if (win == 0) begin
                    resp0_ready = 1'b0;
                    resp1_ready = (k % 2 == 0);
                end else begin
                    resp1_ready = 1'b0;
                    resp0_ready = (k % 2 == 0);
                end
                tick();
            end
        end
        if (win == 0) begin
            resp0_ready = 1'b1;
            resp1_ready = 1'b0;
        end else begin
            resp1_ready = 1'b1;
            resp0_ready = 1'b0;
        end
        tick();
        checkQuiet("done");
    endtask

    initial begin
        // Reset: all outputs quiet asynchronously, even with a request pending
        rst = 1'b1;
        applyStimulus(1'b1, 4'd3, 4'd5, 1'b1, 4'd2, 4'd2, 1'b1, 1'b1);
        #2;
        checkQuiet("reset");
        checkOutput("reset_req0_ready", 16'(req0_ready), 16'(0));
        checkOutput("reset_req1_ready", 16'(req1_ready), 16'(0));
        checkOutput("reset_mul_a",      16'(mul_a),      16'(0));
        checkOutput("reset_mul_b",      16'(mul_b),      16'(0));
        @(negedge clk);
        rst = 1'b0;
        rrModel = 0;

        // Single request 3*5 on requester 0, accepted on the first edge after reset
        serveTxn(1'b1, 4'd3, 4'd5, 1'b0, 4'd0, 4'd0, 0, 1'b0);

        // Contention from reset: order 0,1,0,1 with products 12 and 225
        rst = 1'b1;
        #1;
        rst = 1'b0;
        rrModel = 0;
        for (int t = 0; t < 4; t++)
            serveTxn(1'b1, 4'd3, 4'd4, 1'b1, 4'd15, 4'd15, 0, 1'b1);

        // Backpressure on requester 1 for five cycles, request kept pending
        serveTxn(1'b0, 4'd0, 4'd0, 1'b1, 4'd9, 4'd7, 5, 1'b1);

        // Wrong-port ready while requester 0 owns the response
        serveTxn(1'b1, 4'd6, 4'd11, 1'b0, 4'd0, 4'd0, 4, 1'b0);

        // Exhaustive operand sweep through requester 1
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                serveTxn(1'b0, 4'd0, 4'd0, 1'b1, 4'(a), 4'(b), 0, 1'b0);

        // Randomized requests, operands, stalls and holds
        for (int t = 0; t < 60; t++) begin
            logic rv0, rv1;
            rv0 = 1'($urandom_range(0, 1));
            rv1 = 1'($urandom_range(0, 1));
            if (!rv0 && !rv1) rv1 = 1'b1;
            serveTxn(rv0, 4'($urandom), 4'($urandom), rv1, 4'($urandom), 4'($urandom),
                     int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        // Reset during MUL discards the operation
        applyStimulus(1'b1, 4'd7, 4'd9, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1);
        tick();
        checkOutput("pre_reset_busy", 16'(busy), 16'(1));
        rst = 1'b1;
        #1;
        checkQuiet("midreset");
        checkOutput("midreset_req0_ready", 16'(req0_ready), 16'(0));
        checkOutput("midreset_mul_a",      16'(mul_a),      16'(0));
        checkOutput("midreset_mul_b",      16'(mul_b),      16'(0));
        @(negedge clk);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1);
        rst = 1'b0;
        rrModel = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            checkQuiet("postreset");
        end
        // With rr back at 0, requester 0 wins a tie
        serveTxn(1'b1, 4'd2, 4'd13, 1'b1, 4'd5, 4'd5, 1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
